// File: rtl/instr_decode_stage_pkg.sv
// Shared encodings for the decode stage: opcodes, op classes, ALU codes,
// immediate formats and the decoded-entry bundle.
package instr_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_UPPER
    } op_class_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY, ST_ONE, ST_TWO
    } state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu;
        logic [2:0] funct3;
        op_class_e  op_class;
        logic       reg_write;
        logic       illegal;
    } dec_t;

    // funct7[5] selects SUB only for register ops; SRA/SRL for both
    function automatic logic [3:0] alu_map(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       is_reg
    );
        logic [3:0] code;
        unique case (f3)
            3'd0:    code = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    code = ALU_SLL;
            3'd2:    code = ALU_SLT;
            3'd3:    code = ALU_SLTU;
            3'd4:    code = ALU_XOR;
            3'd5:    code = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J
// immediates to XLEN bits.
module instr_decode_stage_imm_gen
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [11:0] w_i;
    logic signed [11:0] w_s;
    logic signed [12:0] w_b;
    logic signed [31:0] w_u;
    logic signed [20:0] w_j;
    logic               w_unused;

    assign w_i = instr[31:20];
    assign w_s = {instr[31:25], instr[11:7]};
    assign w_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_u = {instr[31:12], 12'b0};
    assign w_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_unused = ^instr[6:0];

    // Signed size casts perform the sign extension to XLEN
    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_I:   imm = XLEN'(w_i);
            IMM_S:   imm = XLEN'(w_s);
            IMM_B:   imm = XLEN'(w_b);
            IMM_U:   imm = XLEN'(w_u);
            IMM_J:   imm = XLEN'(w_j);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I/RV32E decode stage with a 2-entry skid buffer between
// fetch and register file / execute.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      imm,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           funct3,
    output logic [2:0]           op_class,
    output logic                 reg_write,
    output logic                 illegal
);

    localparam logic [5:0] REG_LIM = 6'(NUM_REGS);

    logic [6:0]      w_opc;
    logic [4:0]      w_rd_f;
    logic [4:0]      w_rs1_f;
    logic [4:0]      w_rs2_f;
    logic [2:0]      w_f3;
    logic            w_f7b5;
    op_class_e       w_cls;
    imm_type_e       w_imm_type;
    logic            w_use_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [3:0]      w_alu;
    logic            w_known;
    logic            w_bad_reg;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_new_imm;
    dec_t            w_dec;
    logic            w_accept;
    logic            w_drain;

    state_e          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    dec_t            r_main;
    dec_t            r_skid;
    logic [XLEN-1:0] r_main_imm;
    logic [XLEN-1:0] r_skid_imm;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_skid_pc;

    assign w_opc   = in_instr[6:0];
    assign w_rd_f  = in_instr[11:7];
    assign w_f3    = in_instr[14:12];
    assign w_rs1_f = in_instr[19:15];
    assign w_rs2_f = in_instr[24:20];
    assign w_f7b5  = in_instr[30];

    always_comb begin
        w_cls      = CLS_R;
        w_imm_type = IMM_NONE;
        w_use_rd   = 1'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        w_alu      = ALU_ADD;
        w_known    = 1'b1;
        unique case (w_opc)
            OPC_REG: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_alu     = alu_map(w_f3, w_f7b5, 1'b1);
            end
            OPC_IMM: begin
                w_cls      = CLS_I;
                w_imm_type = IMM_I;
                w_use_rd   = 1'b1;
                w_use_rs1  = 1'b1;
                w_alu      = alu_map(w_f3, w_f7b5, 1'b0);
            end
            OPC_LOAD: begin
                w_cls      = CLS_LOAD;
                w_imm_type = IMM_I;
                w_use_rd   = 1'b1;
                w_use_rs1  = 1'b1;
            end
            OPC_STORE: begin
                w_cls      = CLS_STORE;
                w_imm_type = IMM_S;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                w_cls      = CLS_BRANCH;
                w_imm_type = IMM_B;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_alu      = ALU_SUB;
            end
            OPC_JAL: begin
                w_cls      = CLS_JAL;
                w_imm_type = IMM_J;
                w_use_rd   = 1'b1;
            end
            OPC_JALR: begin
                w_cls      = CLS_JALR;
                w_imm_type = IMM_I;
                w_use_rd   = 1'b1;
                w_use_rs1  = 1'b1;
            end
            OPC_LUI: begin
                w_cls      = CLS_UPPER;
                w_imm_type = IMM_U;
                w_use_rd   = 1'b1;
                w_alu      = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                w_cls      = CLS_UPPER;
                w_imm_type = IMM_U;
                w_use_rd   = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // Only fields the format actually uses can make an RV32E entry illegal
    assign w_bad_reg = (w_use_rd  && ({1'b0, w_rd_f}  >= REG_LIM))
                    || (w_use_rs1 && ({1'b0, w_rs1_f} >= REG_LIM))
                    || (w_use_rs2 && ({1'b0, w_rs2_f} >= REG_LIM));
    assign w_illegal = !w_known || w_bad_reg;

    instr_decode_stage_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr   (in_instr),
        .imm_type(w_imm_type),
        .imm     (w_imm)
    );

    always_comb begin
        w_dec         = '0;
        w_dec.alu     = ALU_ADD;
        w_dec.illegal = 1'b1;
        w_new_imm     = '0;
        if (!w_illegal) begin
            w_dec.rs1       = w_use_rs1 ? w_rs1_f : 5'd0;
            w_dec.rs2       = w_use_rs2 ? w_rs2_f : 5'd0;
            w_dec.rd        = w_use_rd  ? w_rd_f  : 5'd0;
            w_dec.alu       = w_alu;
            w_dec.funct3    = w_f3;
            w_dec.op_class  = w_cls;
            w_dec.reg_write = w_use_rd && (w_rd_f != 5'd0);
            w_dec.illegal   = 1'b0;
            w_new_imm       = w_imm;
        end
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
            r_main_imm  <= '0;
            r_skid_imm  <= '0;
            r_main_pc   <= '0;
            r_skid_pc   <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_dec;
                        r_main_imm  <= w_new_imm;
                        r_main_pc   <= in_pc;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        r_skid     <= w_dec;
                        r_skid_imm <= w_new_imm;
                        r_skid_pc  <= in_pc;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_drain && !w_accept) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_accept && w_drain) begin
                        r_main     <= w_dec;
                        r_main_imm <= w_new_imm;
                        r_main_pc  <= in_pc;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        r_main     <= r_skid;
                        r_main_imm <= r_skid_imm;
                        r_main_pc  <= r_skid_pc;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign rs1       = r_main.rs1;
    assign rs2       = r_main.rs2;
    assign rd        = r_main.rd;
    assign imm       = r_main_imm;
    assign alu_ctrl  = ALUCTRL_W'(r_main.alu);
    assign funct3    = r_main.funct3;
    assign op_class  = r_main.op_class;
    assign reg_write = r_main.reg_write;
    assign illegal   = r_main.illegal;

endmodule
